// File: rtl/ar_mux21_arb.sv
// ar_mux21_arb: round-robin arbiter that shares one 2:1 mux output between two
// requesters, with a per-grant beat cap so neither side can starve the other.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   req[1:0]        per-requester "beat pending", held until its last beat moves
//   last[1:0]       per-requester end-of-packet flag, sampled on transfer only
//   a0, a1          requester data (mux inputs 0 / 1)
//   ready           downstream accepts y this cycle
//   gnt[1:0]        one-hot registered grant, 00 = idle
//   sel             registered mux select (0 -> a0, 1 -> a1)
//   y               mux output, combinational from a0/a1
//   y_valid         gnt[sel] & req[sel]
//   xfer            y_valid & ready
//   beat_cnt        beats transferred in the current grant

// Plain 2:1 data mux; no storage on the data path.
module ar_mux21 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    output logic [WIDTH-1:0] y
);
    assign y = sel ? a1 : a0;
endmodule

module ar_mux21_arb #(
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [1:0]       last,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic             ready,
    output logic [1:0]       gnt,
    output logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic             xfer,
    output logic [CNT_W-1:0] beat_cnt
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             sel_q, sel_d;
    logic             ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [CNT_W-1:0] cnt_inc;
    logic             cap_hit;
    logic             cur;
    logic             rel_a, rel_b, rel_c;
    logic [1:0]       req_m;

    // Single requester wins outright; on a tie the pointer decides.
    function automatic state_e arb(input logic p, input logic [1:0] r);
        state_e s;
        s = IDLE;
        if (r == 2'b01)      s = G0;
        else if (r == 2'b10) s = G1;
        else if (r == 2'b11) s = p ? G1 : G0;
        return s;
    endfunction

    ar_mux21 #(.WIDTH(WIDTH)) u_mux (
        .sel (sel_q),
        .a0  (a0),
        .a1  (a1),
        .y   (y)
    );

    // In G0/G1 sel_q already names the granted requester; in IDLE gnt is 00.
    assign y_valid  = gnt_q[sel_q] & req[sel_q];
    assign xfer     = y_valid & ready;
    assign gnt      = gnt_q;
    assign sel      = sel_q;
    assign beat_cnt = cnt_q;

    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign cap_hit  = (cnt_inc == CNT_W'(MAX_BURST));

    // Next-state, pointer and beat-count logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        req_m   = req;
        cur     = (state_q == G1);
        rel_a   = 1'b0;
        rel_b   = 1'b0;
        rel_c   = 1'b0;

        case (state_q)
            IDLE: state_d = arb(ptr_q, req);
            G0, G1: begin
                rel_a = xfer & last[cur];
                rel_b = xfer & cap_hit;
                rel_c = ~req[cur];
                if (rel_a | rel_b | rel_c) begin
                    ptr_d = ~cur;
                    cnt_d = '0;
                    // A finished or abandoned requester may not win the re-arbitration;
                    // a capped one may, if the other side is idle.
                    if (rel_a | rel_c) req_m[cur] = 1'b0;
                    state_d = arb(~cur, req_m);
                end else if (xfer) begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase

        // sel follows the grant and holds its last value while idle.
        if (state_d == G1)      sel_d = 1'b1;
        else if (state_d == G0) sel_d = 1'b0;

        gnt_d = {state_d == G1, state_d == G0};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            sel_q   <= 1'b0;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
